// File: rtl/fifo_fm0_tx.sv
// FM0 transmitter on the drain side of the tag's byte FIFO: pops bytes, serializes them
// MSB first, and closes every frame with a dummy-1 end-of-signaling bit.
module fifo_fm0_tx #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic       start_i,
    input  logic       fifo_empty_i,
    input  logic [7:0] fifo_data_i,
    output logic       fifo_read_o,
    output logic       tx_out_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] bytes_sent_o
);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(HALF_DIV - 1);
    localparam logic [DATA_W-1:0] BYTES_MAX   = '1;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SHIFT, EOS} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] bytes_q, bytes_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              phase_q, phase_d;
    logic              hold_valid_q, hold_valid_d;
    logic              pf_pend_q, pf_pend_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_c;
    logic              half_end_c;
    logic              prefetch_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            hold_q       <= '0;
            bytes_q      <= '0;
            half_q       <= '0;
            idx_q        <= '0;
            phase_q      <= 1'b0;
            hold_valid_q <= 1'b0;
            pf_pend_q    <= 1'b0;
            tx_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            bytes_q      <= bytes_d;
            half_q       <= half_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            hold_valid_q <= hold_valid_d;
            pf_pend_q    <= pf_pend_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next state, FM0 level and pop strobe; the pop is decided in the same cycle as its condition.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        bytes_d      = bytes_q;
        half_d       = half_q;
        idx_d        = idx_q;
        phase_d      = phase_q;
        hold_valid_d = hold_valid_q;
        pf_pend_d    = 1'b0;
        tx_d         = tx_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        read_c       = 1'b0;
        half_end_c   = (half_q == '0);
        prefetch_c   = (idx_q == '0) && phase_q && (half_q == HALF_RELOAD);

        // Prefetched byte arrives one cycle after its pop.
        if (pf_pend_q) begin
            hold_d       = fifo_data_i;
            hold_valid_d = 1'b1;
        end

        if (!en_i) begin
            if (state_q != IDLE) begin
                state_d      = IDLE;
                tx_d         = 1'b0;
                busy_d       = 1'b0;
                hold_valid_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        bytes_d      = '0;
                        hold_valid_d = 1'b0;
                        if (fifo_empty_i) begin
                            done_d = 1'b1;
                        end else begin
                            read_c  = 1'b1;
                            busy_d  = 1'b1;
                            state_d = FETCH;
                        end
                    end
                end
                FETCH: state_d = CAPTURE;
                CAPTURE: begin
                    shift_d = fifo_data_i;
                    idx_d   = '1;
                    half_d  = HALF_RELOAD;
                    phase_d = 1'b0;
                    tx_d    = ~tx_q;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    read_c    = prefetch_c && !fifo_empty_i;
                    pf_pend_d = read_c;
                    if (!half_end_c) begin
                        half_d = half_q - CNT_W'(1);
                    end else begin
                        half_d  = HALF_RELOAD;
                        phase_d = ~phase_q;
                        if (!phase_q) begin
                            if (!shift_q[idx_q]) tx_d = ~tx_q;
                        end else begin
                            tx_d = ~tx_q;
                            if (idx_q != '0) begin
                                idx_d = idx_q - IDX_W'(1);
                            end else begin
                                if (bytes_q != BYTES_MAX) bytes_d = bytes_q + DATA_W'(1);
                                idx_d = '1;
                                // A prefetch still in flight is taken straight from the FIFO port.
                                if (hold_valid_q || pf_pend_q) begin
                                    shift_d      = hold_valid_q ? hold_q : fifo_data_i;
                                    hold_valid_d = 1'b0;
                                end else begin
                                    state_d = EOS;
                                end
                            end
                        end
                    end
                end
                EOS: begin
                    if (!half_end_c) begin
                        half_d = half_q - CNT_W'(1);
                    end else begin
                        half_d  = HALF_RELOAD;
                        phase_d = ~phase_q;
                        if (phase_q) begin
                            tx_d    = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign fifo_read_o  = read_c;
    assign tx_out_o     = tx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign bytes_sent_o = bytes_q;
endmodule

// File: tb/tb_fifo_fm0_tx.sv
// Bench for fifo_fm0_tx: two instances (HALF_DIV 4 and 2) share one FIFO model; frames are
// compared cycle by cycle against an FM0 waveform built from the byte list.
module tb_fifo_fm0_tx;
    typedef logic [7:0] bq_t[$];
    typedef bit wq_t[$];
    typedef struct {
        bit          use2;
        int          n;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          exp_sent;
        int          exp_done_j;
        logic [15:0] exp_halves;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n, en, start, sel, fifo_empty;
    logic [7:0] fifo_data;
    logic       en4, start4, empty4, rd4, tx4, busy4, done4;
    logic       en2, start2, empty2, rd2, tx2, busy2, done2;
    logic [7:0] bs4, bs2;
    logic       rd_m, tx_m, busy_m, done_m;
    logic [7:0] bs_m;

    logic [7:0] fifo_q[$];
    int         rd_count = 0;
    int         rd_viol  = 0;
    logic       last_rd;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    assign en4    = en & ~sel;
    assign start4 = start & ~sel;
    assign empty4 = fifo_empty | sel;
    assign en2    = en & sel;
    assign start2 = start & sel;
    assign empty2 = fifo_empty | ~sel;
    assign rd_m   = sel ? rd2 : rd4;
    assign tx_m   = sel ? tx2 : tx4;
    assign busy_m = sel ? busy2 : busy4;
    assign done_m = sel ? done2 : done4;
    assign bs_m   = sel ? bs2 : bs4;

    fifo_fm0_tx #(.HALF_DIV(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .en_i(en4), .start_i(start4), .fifo_empty_i(empty4),
        .fifo_data_i(fifo_data), .fifo_read_o(rd4), .tx_out_o(tx4), .busy_o(busy4),
        .done_o(done4), .bytes_sent_o(bs4)
    );

    fifo_fm0_tx #(.HALF_DIV(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .en_i(en2), .start_i(start2), .fifo_empty_i(empty2),
        .fifo_data_i(fifo_data), .fifo_read_o(rd2), .tx_out_o(tx2), .busy_o(busy2),
        .done_o(done2), .bytes_sent_o(bs2)
    );

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // FM0: level flips at every bit start, and again at mid-bit for a 0; frame ends with a dummy 1.
    function automatic wq_t fm0_model(input bq_t bytes, input int hd);
        wq_t w;
        bit  bits[$];
        bit  lvl;
        lvl = 1'b0;
        foreach (bytes[i]) for (int k = 7; k >= 0; k--) bits.push_back(bytes[i][k]);
        bits.push_back(1'b1);
        foreach (bits[i]) begin
            lvl = ~lvl;
            repeat (hd) w.push_back(lvl);
            if (!bits[i]) lvl = ~lvl;
            repeat (hd) w.push_back(lvl);
        end
        return w;
    endfunction

    // One clock from negedge to negedge; the FIFO pops just after the edge that saw the read.
    task automatic tick();
        #1;
        last_rd = rd_m;
        if (last_rd && fifo_empty) rd_viol++;
        @(posedge clk);
        #1;
        if (last_rd) begin
            rd_count++;
            if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
        end
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
    endtask

    task automatic flush();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic run_frame(input string tag, input bit s2, input bq_t bytes, input bit restart,
                             input bit late, output wq_t obs, output int done_j);
        int  hd, n, len, jp, r0, v0, tx_bad, busy_bad, done_cnt, exp_done_j, sent;
        bit  rd0, exp_tx, exp_busy;
        wq_t w;
        hd = s2 ? 2 : 4;
        n  = bytes.size();
        sel = s2;
        foreach (bytes[i]) fifo_q.push_back(bytes[i]);
        fifo_empty = (fifo_q.size() == 0);
        w   = fm0_model(bytes, hd);
        len = (n > 0) ? w.size() : 0;
        jp  = 3 + (8 * n - 1) * 2 * hd + hd;
        exp_done_j = (n > 0) ? 3 + len : 1;
        r0 = rd_count; v0 = rd_viol;
        tx_bad = 0; busy_bad = 0; done_cnt = 0; done_j = -1; rd0 = 1'b0;
        obs.delete();
        start = 1'b1;
        for (int j = 0; j <= len + 6; j++) begin
            if (j == 1 || j == 11) start = 1'b0;
            if (restart && n > 0 && j == 10) start = 1'b1;
            if (late && n > 0 && j == jp + 1) begin
                fifo_q.push_back(8'hE7);
                fifo_empty = 1'b0;
            end
            if (j > 0) begin
                exp_tx   = (j >= 3 && j < 3 + len) ? w[j-3] : 1'b0;
                exp_busy = (n > 0) && (j < 3 + len);
                if (tx_m !== exp_tx) tx_bad++;
                if (busy_m !== exp_busy) busy_bad++;
                if (j >= 3 && j < 3 + len) obs.push_back(tx_m);
                if (done_m === 1'b1) begin
                    done_cnt++;
                    if (done_j < 0) done_j = j;
                end
            end
            tick();
            if (j == 0) rd0 = last_rd;
        end
        sent = (n > 255) ? 255 : n;
        check({tag, "_tx_bad_cycles"}, tx_bad, 0);
        check({tag, "_busy_bad_cycles"}, busy_bad, 0);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_done_cycle"}, done_j, exp_done_j);
        check({tag, "_read_on_start"}, rd0, (n > 0) ? 1 : 0);
        check({tag, "_reads"}, rd_count - r0, n);
        check({tag, "_read_while_empty"}, rd_viol - v0, 0);
        check({tag, "_bytes_sent"}, bs_m, sent);
        if (late) flush();
    endtask

    initial begin
        vec_t vecs[4];
        bq_t  b;
        wq_t  obs;
        int   dj, r0, cnt, hd;
        logic [15:0] halves;

        vecs[0] = '{1'b0, 1, 8'hA5, 8'h00, 8'h00, 1, 75, 16'b1101001010110100};
        vecs[1] = '{1'b0, 3, 8'h00, 8'hFF, 8'h3C, 3, 203, 16'b1010101010101010};
        vecs[2] = '{1'b1, 2, 8'hC3, 8'h5A, 8'h00, 2, 71, 16'b1100101010101100};
        vecs[3] = '{1'b0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 16'h0000};

        reset_n = 1'b0; en = 1'b0; start = 1'b0; sel = 1'b0;
        fifo_empty = 1'b1; fifo_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx4, busy4, done4, rd4, bs4, tx2, busy2, done2, rd2, bs2}, 0);
        reset_n = 1'b1;
        en = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            b.delete();
            if (vecs[i].n > 0) b.push_back(vecs[i].b0);
            if (vecs[i].n > 1) b.push_back(vecs[i].b1);
            if (vecs[i].n > 2) b.push_back(vecs[i].b2);
            run_frame($sformatf("vec%0d", i), vecs[i].use2, b, 1'b0, (i == 2), obs, dj);
            check($sformatf("vec%0d_done_at", i), dj, vecs[i].exp_done_j);
            check($sformatf("vec%0d_sent", i), bs_m, vecs[i].exp_sent);
            if (vecs[i].n > 0) begin
                hd = vecs[i].use2 ? 2 : 4;
                for (int k = 0; k < 16; k++) halves[15-k] = obs[hd*k];
                check($sformatf("vec%0d_halves", i), halves, vecs[i].exp_halves);
            end
        end

        // en dropped during bit 4 of the second byte
        sel = 1'b0;
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        fifo_empty = 1'b0;
        r0 = rd_count;
        start = 1'b1;
        for (int j = 0; j < 93; j++) begin
            tick();
            start = 1'b0;
        end
        check("endrop_busy_before", busy_m, 1);
        en = 1'b0;
        tick();
        check("endrop_tx", tx_m, 0);
        check("endrop_busy", busy_m, 0);
        check("endrop_bytes", bs_m, 1);
        en = 1'b1;
        cnt = 0;
        repeat (20) begin
            tick();
            if (done_m || busy_m) cnt++;
        end
        check("endrop_no_done", cnt, 0);
        check("endrop_bytes_hold", bs_m, 1);
        check("endrop_reads", rd_count - r0, 2);
        flush();
        b.delete(); b.push_back(8'h5A);
        run_frame("after_endrop", 1'b0, b, 1'b0, 1'b0, obs, dj);

        // asynchronous reset mid-frame
        fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB); fifo_q.push_back(8'hCC);
        fifo_empty = 1'b0;
        start = 1'b1;
        for (int j = 0; j < 40; j++) begin
            tick();
            start = 1'b0;
        end
        check("rst_busy_before", busy_m, 1);
        #2 reset_n = 1'b0;
        #1 check("rst_outputs_async", {tx_m, busy_m, done_m, rd_m, bs_m}, 0);
        @(negedge clk);
        r0 = rd_count;
        cnt = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (20) begin
            tick();
            if (busy_m || tx_m || done_m) cnt++;
        end
        check("rst_no_reads", rd_count - r0, 0);
        check("rst_quiet_outputs", cnt, 0);
        flush();

        // start while disabled is ignored
        fifo_q.push_back(8'h77);
        fifo_empty = 1'b0;
        en = 1'b0;
        r0 = rd_count;
        cnt = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) begin
            if (busy_m || done_m) cnt++;
            tick();
        end
        check("en_low_start_reads", rd_count - r0, 0);
        check("en_low_start_outputs", cnt, 0);
        en = 1'b1;
        flush();

        // bytes_sent saturates
        b.delete();
        for (int i = 0; i < 256; i++) b.push_back(8'($urandom));
        run_frame("saturate", 1'b1, b, 1'b0, 1'b0, obs, dj);

        for (int f = 0; f < 8; f++) begin
            int n;
            bit s2, rs, lt;
            n  = $urandom_range(6, 1);
            s2 = 1'($urandom_range(1, 0));
            rs = 1'($urandom_range(1, 0));
            lt = 1'($urandom_range(1, 0));
            b.delete();
            for (int i = 0; i < n; i++) b.push_back(8'($urandom));
            run_frame($sformatf("rand%0d", f), s2, b, rs, lt, obs, dj);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
